decode_arbiter: RTL and testbench
=================================

Name: decode_arbiter

Overview:
- Shares one 8-bit count-gated decoder between NUM_REQ requesters.
- Each requester presents a data byte and a 4-bit cycle count. The arbiter grants requesters in round-robin order and drives the decoder's data/count inputs.
- It waits for a full, phase-aligned decoder period, captures the decoded byte and returns it with a one-cycle done pulse.
- Sits between the requester-side front end and the decoder instance.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TMO, 40: max cycles spent waiting for any single dec_ready pulse before aborting.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held until that requester's done.
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]; stable while req[i] is high.
- req_cnt  in  4*NUM_REQ  decode period for requester i at [4i+3:4i].
- gnt  out  NUM_REQ  one-hot grant, high from ARB exit through RESP inclusive.
- done  out  NUM_REQ  one-cycle completion pulse for the granted requester.
- res_data  out  8  result byte, valid in the done cycle, held until the next done.
- err  out  1  valid with done: 1 = rejected or timed out; res_data is then 8'h00.
- busy  out  1  high in every state except IDLE.
- dec_din  out  8  decoder data input.
- dec_cin  out  4  decoder count input.
- dec_rd  in  8  decoder data output.
- dec_ready  in  1  decoder ready strobe.

Behaviour:
- Reset values (RST low, async):
  - state = IDLE; gnt, done, err = 0; res_data = 0.
  - dec_din = 0, dec_cin = 4'd2.
  - rr_ptr = 0; timeout counter = 0.
- Idle and decoder-free drive: dec_din = 0, dec_cin = 2 whenever no grant is active.
- Round-robin pointer: rr_ptr holds the index after the last granted requester.
- IDLE -> ARB: when any req bit is high.
- ARB (1 cycle):
  - Select the first set req bit scanning from rr_ptr upward with wrap.
  - Latch its data/cnt into internal registers; set gnt.
  - rr_ptr = selected + 1, wrapping at NUM_REQ.
  - If latched cnt < 2, go to RESP with err = 1; the decoder is not engaged. Count 0 never matches in the decoder, and count 1 yields zero data.
  - Otherwise go to SYNC.
- Datapath hold:
  - From the ARB exit through the end of CAPT, dec_din and dec_cin are driven from the latched registers, not live inputs.
  - Requester input changes after ARB have no effect.
- SYNC: discard the first dec_ready seen after entry, since it may close a partial period, then go to CAPT.
- CAPT: on the next dec_ready, register dec_rd into res_data with err = 0, then go to RESP.
- Timeout:
  - The counter clears on entry to SYNC and to CAPT, and increments each cycle in those states.
  - On reaching TMO with no dec_ready: go to RESP, err = 1, res_data = 0.
- RESP (1 cycle): done[sel] = 1, gnt held; next state IDLE. done is registered, so it aligns with RESP.
- Latency, valid request with cnt N: ARB cycle + SYNC + CAPT + RESP.
  - Worst case ≈ 2N + 3 cycles from first req to done.
  - Best case N + 3 cycles, when a decoder ready lands one cycle after ARB.
- A new grant is possible the cycle after RESP (IDLE then ARB), i.e. one idle cycle minimum between services.
- Simultaneous requests are served one per transaction in rotating order. A requester that deasserts req before grant is skipped, with no error.
- A req dropped mid-service is ignored; the transaction completes and done still pulses.
- Reset mid-transaction: immediate return to reset values; no done is issued.

Test Plan:
- Single request: req[2] = 1, data 8'hA5, cnt 4 -> gnt = 4'b0100; after a discarded ready, res_data = 8'hA5, err = 0, done[2] pulses once, within ≤ 11 cycles.
- Contention: req = 4'b1011 held, all cnt 3, distinct bytes, rr_ptr = 0 -> grants in order 0, 1, 3, 0, …; each done carries its own byte.
- Illegal counts: cnt 0 on req[1], then cnt 1 on req[0] -> each gets done with err = 1, res_data = 0, and the ARB-to-done interval is 2 cycles.
- Timeout: decoder model holds dec_ready low, cnt 5 -> done with err = 1 exactly TMO cycles after SYNC entry; busy drops the next cycle.
- Input change after grant: req_data[7:0] changes from 8'h3C to 8'hFF one cycle after ARB -> dec_din stays 8'h3C and res_data = 8'h3C.
- Reset mid-CAPT: assert RST low asynchronously -> gnt, busy, done = 0 immediately and dec_cin = 2; after release with req still high, the service restarts from ARB with rr_ptr = 0.

Source files
------------

// File: rtl/decode_arbiter.sv
// Round-robin arbiter sharing one count-gated decoder.
// Serves one requester per transaction and returns the decoded byte.
module decode_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TMO     = 40
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [4*NUM_REQ-1:0] req_cnt,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           res_data,
  output logic                 err,
  output logic                 busy,
  output logic [7:0]           dec_din,
  output logic [3:0]           dec_cin,
  input  logic [7:0]           dec_rd,
  input  logic                 dec_ready
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = IW + 1;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SYNC,
    CAPT,
    RESP
  } state_t;

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [TW-1:0]        tmo;

  logic                 found;
  logic [IW-1:0]        sel;
  logic [SW-1:0]        sum;
  logic [7:0]           data_sel;
  logic [3:0]           cnt_sel;
  logic [NUM_REQ-1:0]   onehot;
  logic [IW-1:0]        nxt_ptr;
  logic                 tmo_hit;

  // first set request at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + SW'(i);
      if (sum >= SW'(NUM_REQ))
        sum = sum - SW'(NUM_REQ);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        sel   = sum[IW-1:0];
      end
    end
  end

  assign data_sel = req_data[8*sel +: 8];
  assign cnt_sel  = req_cnt[4*sel +: 4];
  assign onehot   = NUM_REQ'(1) << sel;
  assign nxt_ptr  = (sel == IW'(NUM_REQ - 1)) ? '0
                                              : sel + IW'(1);
  assign tmo_hit  = (tmo == TW'(TMO - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      res_data <= '0;
      dec_din  <= '0;
      dec_cin  <= 4'd2;
      rr_ptr   <= '0;
      tmo      <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (|req)
            state <= ARB;
        end
        ARB: begin
          if (!found) begin
            state <= IDLE;
          end else begin
            gnt    <= onehot;
            rr_ptr <= nxt_ptr;
            // counts 0 and 1 never yield valid data
            if (cnt_sel < 4'd2) begin
              state    <= RESP;
              done     <= onehot;
              err      <= 1'b1;
              res_data <= '0;
            end else begin
              state   <= SYNC;
              tmo     <= '0;
              dec_din <= data_sel;
              dec_cin <= cnt_sel;
            end
          end
        end
        SYNC: begin
          if (dec_ready) begin
            state <= CAPT;
            tmo   <= '0;
          end else if (tmo_hit) begin
            state    <= RESP;
            done     <= gnt;
            err      <= 1'b1;
            res_data <= '0;
            dec_din  <= '0;
            dec_cin  <= 4'd2;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        CAPT: begin
          if (dec_ready) begin
            state    <= RESP;
            done     <= gnt;
            err      <= 1'b0;
            res_data <= dec_rd;
            dec_din  <= '0;
            dec_cin  <= 4'd2;
          end else if (tmo_hit) begin
            state    <= RESP;
            done     <= gnt;
            err      <= 1'b1;
            res_data <= '0;
            dec_din  <= '0;
            dec_cin  <= 4'd2;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        RESP: begin
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_arbiter.sv
// Directed bench for decode_arbiter with a simple
// periodic decoder model.
module tb_decode_arbiter;

  localparam int N   = 4;
  localparam int TMO = 40;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [4*N-1:0] req_cnt;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [7:0]     res_data;
  logic           err;
  logic           busy;
  logic [7:0]     dec_din;
  logic [3:0]     dec_cin;
  logic [7:0]     dec_rd;
  logic           dec_ready;

  logic           rdy_en;
  logic [3:0]     pc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  decode_arbiter #(.NUM_REQ(N), .TMO(TMO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .req_data  (req_data),
    .req_cnt   (req_cnt),
    .gnt       (gnt),
    .done      (done),
    .res_data  (res_data),
    .err       (err),
    .busy      (busy),
    .dec_din   (dec_din),
    .dec_cin   (dec_cin),
    .dec_rd    (dec_rd),
    .dec_ready (dec_ready)
  );

  always #5 CLK = ~CLK;

  // decoder: ready once every dec_cin cycles, echoes dec_din
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      pc <= '0;
    else if (pc >= dec_cin - 4'd1)
      pc <= '0;
    else
      pc <= pc + 4'd1;
  end

  assign dec_ready = rdy_en && (pc == dec_cin - 4'd1);
  assign dec_rd    = dec_ready ? dec_din : 8'hEE;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [3:0] cnt;
    logic       e;
    logic [7:0] res;
    int         maxc;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_rst();
    RST = 1'b0;
    #3;
    RST = 1'b1;
    step();
  endtask

  task automatic run_txn(input int i,
                         input logic [7:0] d,
                         input logic [3:0] c,
                         output int n);
    req_data[8*i +: 8] = d;
    req_cnt[4*i +: 4]  = c;
    req[i] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (done == '0 && n < 60);
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == '0 && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [N-1:0] oh;
    int order[4];
    logic [7:0] bytes[4];

    req      = '0;
    req_data = '0;
    req_cnt  = '0;
    rdy_en   = 1'b1;

    tbl[0] = '{2, 8'hA5, 4'd4,  1'b0, 8'hA5, 11};
    tbl[1] = '{1, 8'h77, 4'd0,  1'b1, 8'h00, 2};
    tbl[2] = '{0, 8'h55, 4'd1,  1'b1, 8'h00, 2};
    tbl[3] = '{3, 8'h5A, 4'd2,  1'b0, 8'h5A, 7};
    tbl[4] = '{1, 8'hC3, 4'd15, 1'b0, 8'hC3, 33};

    #12;
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err",  32'(err), 0);
    chk("rst_res",  32'(res_data), 0);
    chk("rst_din",  32'(dec_din), 0);
    chk("rst_cin",  32'(dec_cin), 2);
    chk("rst_busy", 32'(busy), 0);
    RST = 1'b1;
    step();
    step();

    for (int k = 0; k < 5; k++) begin
      oh = N'(1) << tbl[k].idx;
      run_txn(tbl[k].idx, tbl[k].data, tbl[k].cnt, n);
      chk($sformatf("t%0d_done", k), 32'(done), 32'(oh));
      chk($sformatf("t%0d_gnt", k), 32'(gnt), 32'(oh));
      chk($sformatf("t%0d_err", k), 32'(err), 32'(tbl[k].e));
      chk($sformatf("t%0d_res", k), 32'(res_data),
          32'(tbl[k].res));
      if (tbl[k].e)
        chk($sformatf("t%0d_lat", k), 32'(n), 2);
      else
        chk($sformatf("t%0d_lat_ok", k),
            32'(n <= tbl[k].maxc), 1);
      req = '0;
      step();
      chk($sformatf("t%0d_pulse", k), 32'(done), 0);
      chk($sformatf("t%0d_idle", k), 32'(busy), 0);
      chk($sformatf("t%0d_hold", k), 32'(res_data),
          32'(tbl[k].res));
    end

    // contention: rotating order from rr_ptr = 0
    pulse_rst();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_cnt  = {4'd3, 4'd3, 4'd3, 4'd3};
    order = '{0, 1, 3, 0};
    bytes = '{8'h11, 8'h22, 8'h44, 8'h11};
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (done == '0 && n < 40);
      oh = N'(1) << order[k];
      chk($sformatf("rr%0d_done", k), 32'(done), 32'(oh));
      chk($sformatf("rr%0d_res", k), 32'(res_data),
          32'(bytes[k]));
      chk($sformatf("rr%0d_err", k), 32'(err), 0);
    end
    req = '0;
    step();
    step();

    // timeout with a silent decoder
    rdy_en = 1'b0;
    req_data[31:24] = 8'h99;
    req_cnt[15:12]  = 4'd5;
    req[3] = 1'b1;
    wait_gnt(n);
    chk("tmo_gnt", 32'(gnt), 32'(4'b1000));
    n = 0;
    do begin
      step();
      n++;
    end while (done == '0 && n < 100);
    chk("tmo_lat",  32'(n), TMO);
    chk("tmo_done", 32'(done), 32'(4'b1000));
    chk("tmo_err",  32'(err), 1);
    chk("tmo_res",  32'(res_data), 0);
    req = '0;
    step();
    chk("tmo_busy", 32'(busy), 0);
    rdy_en = 1'b1;
    step();

    // input change after grant must not reach the decoder
    req_data[7:0] = 8'h3C;
    req_cnt[3:0]  = 4'd3;
    req[0] = 1'b1;
    wait_gnt(n);
    chk("chg_gnt", 32'(gnt), 32'(4'b0001));
    req_data[7:0] = 8'hFF;
    step();
    chk("chg_din", 32'(dec_din), 32'(8'h3C));
    n = 0;
    while (done == '0 && n < 40) begin
      step();
      n++;
    end
    chk("chg_done", 32'(done), 32'(4'b0001));
    chk("chg_res",  32'(res_data), 32'(8'h3C));
    req = '0;
    step();
    step();

    // reset while in CAPT, then restart from rr_ptr = 0
    pulse_rst();
    req_data[23:16] = 8'h6B;
    req_data[31:24] = 8'hB6;
    req_cnt[11:8]   = 4'd8;
    req_cnt[15:12]  = 4'd8;
    req = 4'b1100;
    wait_gnt(n);
    chk("rc_gnt1", 32'(gnt), 32'(4'b0100));
    n = 0;
    while (!dec_ready && n < 20) begin
      step();
      n++;
    end
    step();
    #2;
    RST = 1'b0;
    #1;
    chk("rc_gnt0",  32'(gnt), 0);
    chk("rc_busy0", 32'(busy), 0);
    chk("rc_done0", 32'(done), 0);
    chk("rc_cin",   32'(dec_cin), 2);
    @(negedge CLK);
    RST = 1'b1;
    wait_gnt(n);
    chk("rc_gnt2", 32'(gnt), 32'(4'b0100));
    n = 0;
    while (done == '0 && n < 40) begin
      step();
      n++;
    end
    chk("rc_done", 32'(done), 32'(4'b0100));
    chk("rc_res",  32'(res_data), 32'(8'h6B));
    req = '0;
    step();
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
